// File: rtl/pc_sequencer.sv
// Program-counter sequencer: Start/Done handshake, program base select, PC-relative branches.
// Optional taken-branch and run-cycle counters are built when BRANCH_STATS_EN is defined.
module pc_sequencer #(
    parameter int          D       = 12,
    parameter int unsigned P0_BASE = 0,
    parameter int unsigned P1_BASE = 0,
    parameter int unsigned P2_BASE = 0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [1:0]   ProgSel,
    input  logic         Stall,
    input  logic         BranchEn,
    input  logic         Taken,
    input  logic [5:0]   BranchIdx,
    input  logic         Halt,
    output logic [5:0]   LutAddr,
    input  logic [D-1:0] LutTarget,
    output logic [D-1:0] PC,
    output logic         Running,
`ifdef BRANCH_STATS_EN
    output logic [15:0]  BranchCnt,
    output logic [15:0]  CycleCnt,
`endif
    output logic         Done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [D-1:0]   pc_reg, pc_next;
    logic [D-1:0]   base_tab [4];
    logic [D-1:0]   base_sel;
    logic           branch_fire;

    // Program-select 3 aliases program 0.
    for (genvar gi = 0; gi < 4; gi++) begin : g_base
        assign base_tab[gi] = (gi == 1) ? D'(P1_BASE) :
                              (gi == 2) ? D'(P2_BASE) : D'(P0_BASE);
    end

    assign base_sel    = base_tab[ProgSel];
    assign branch_fire = (state_reg == ST_RUN) && !Halt && !Stall && BranchEn && Taken;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    state_next = ST_ARM;
                    pc_next    = base_sel;
                end
            end
            ST_ARM: begin
                // Base keeps tracking ProgSel until Start falls.
                pc_next = base_sel;
                if (!Start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Halt) begin
                    state_next = ST_DONE;
                end else if (Stall) begin
                    pc_next = pc_reg;
                end else if (BranchEn && Taken) begin
                    pc_next = pc_reg + LutTarget;
                end else begin
                    pc_next = pc_reg + D'(1);
                end
            end
            ST_DONE: begin
                if (Start) begin
                    state_next = ST_ARM;
                    pc_next    = base_sel;
                end
            end
            default: begin
                state_next = ST_IDLE;
                pc_next    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] branch_cnt_reg;
    logic [15:0] cycle_cnt_reg;

    always_ff @(posedge Clk) begin
        if (Reset || state_next == ST_ARM) begin
            branch_cnt_reg <= '0;
            cycle_cnt_reg  <= '0;
        end else if (state_reg == ST_RUN) begin
            if (cycle_cnt_reg != 16'hFFFF) begin
                cycle_cnt_reg <= cycle_cnt_reg + 16'd1;
            end
            if (branch_fire && branch_cnt_reg != 16'hFFFF) begin
                branch_cnt_reg <= branch_cnt_reg + 16'd1;
            end
        end
    end

    assign BranchCnt = branch_cnt_reg;
    assign CycleCnt  = cycle_cnt_reg;
`else
    logic unused_fire;
    assign unused_fire = branch_fire;
`endif

    assign LutAddr = BranchIdx;
    assign PC      = pc_reg;
    assign Running = (state_reg == ST_RUN);
    assign Done    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run
// against a behavioural model of the sequencer's rules.
module tb_pc_sequencer;
    localparam int D = 12;
    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DONE = 3;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0, Start = 1'b0, Stall = 1'b0;
    logic         BranchEn = 1'b0, Taken = 1'b0, Halt = 1'b0;
    logic [1:0]   ProgSel = 2'd0;
    logic [5:0]   BranchIdx = 6'd0;
    logic [5:0]   LutAddr;
    logic [D-1:0] LutTarget = '0;
    logic [D-1:0] PC;
    logic         Running, Done;
`ifdef BRANCH_STATS_EN
    logic [15:0]  BranchCnt, CycleCnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int m_mode = M_IDLE, m_pc = 0, m_bcnt = 0, m_ccnt = 0;

    pc_sequencer #(.D(D), .P0_BASE(5), .P1_BASE(40), .P2_BASE(200)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Stall(Stall),
        .BranchEn(BranchEn), .Taken(Taken), .BranchIdx(BranchIdx), .Halt(Halt),
        .LutAddr(LutAddr), .LutTarget(LutTarget), .PC(PC), .Running(Running),
`ifdef BRANCH_STATS_EN
        .BranchCnt(BranchCnt), .CycleCnt(CycleCnt),
`endif
        .Done(Done)
    );

    always #5 Clk = ~Clk;

    function automatic int base_of(input logic [1:0] s);
        return (s == 2'd1) ? 40 : (s == 2'd2) ? 200 : 5;
    endfunction

    function automatic int signed_of(input logic [D-1:0] t);
        return int'(t) - (t[D-1] ? 4096 : 0);
    endfunction

    // Apply one cycle of inputs, advance the model, and step past the edge.
    task automatic cyc(input logic rst, input logic st, input logic [1:0] sel,
                       input logic stl, input logic be, input logic tk,
                       input logic [5:0] idx, input logic hlt, input logic [D-1:0] tgt);
        Reset = rst; Start = st; ProgSel = sel; Stall = stl;
        BranchEn = be; Taken = tk; BranchIdx = idx; Halt = hlt; LutTarget = tgt;
        if (rst) begin
            m_mode = M_IDLE; m_pc = 0; m_bcnt = 0; m_ccnt = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: if (st) begin
                    m_mode = M_ARM; m_pc = base_of(sel); m_bcnt = 0; m_ccnt = 0;
                end
                M_ARM: begin
                    m_pc = base_of(sel);
                    if (!st) m_mode = M_RUN;
                end
                default: begin
                    if (m_ccnt < 65535) m_ccnt++;
                    if (hlt) m_mode = M_DONE;
                    else if (stl) m_pc = m_pc;
                    else if (be && tk) begin
                        m_pc = (m_pc + signed_of(tgt) + 4096) % 4096;
                        if (m_bcnt < 65535) m_bcnt++;
                    end else m_pc = (m_pc + 1) % 4096;
                end
            endcase
        end
        @(posedge Clk);
        #1;
        $display("txn rst=%b st=%b sel=%0d stl=%b br=%b%b idx=%0d hlt=%b tgt=%0d -> PC=%0d run=%b done=%b",
                 rst, st, sel, stl, be, tk, idx, hlt, tgt, PC, Running, Done);
    endtask

    task automatic goto_pc(input int target);
        cyc(0, 0, 2'd0, 0, 1, 1, 6'($urandom), 0, 12'(target - m_pc));
    endtask

    task automatic test_reset();
        cyc(1, 0, 2'd0, 0, 0, 0, 6'd42, 0, 12'($urandom));
        cyc(1, 1, 2'd1, 0, 0, 0, 6'd42, 0, 12'($urandom));
        n_vec++;
        if (PC !== 12'd0 || Running !== 1'b0 || Done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: PC=%0d Running=%b Done=%b, want 0/0/0", PC, Running, Done);
        end
        n_vec++;
        if (LutAddr !== 6'd42) begin
            n_err++;
            $display("FAIL lut_addr_passthru: LutAddr=%0d, want 42", LutAddr);
        end
`ifdef BRANCH_STATS_EN
        n_vec++;
        if (BranchCnt !== 16'd0 || CycleCnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_stats: BranchCnt=%0d CycleCnt=%0d, want 0/0", BranchCnt, CycleCnt);
        end
`endif
    endtask

    task automatic test_arm();
        cyc(0, 1, 2'd1, 0, 0, 0, 6'd0, 0, 12'd0);
        n_vec++;
        if (PC !== 12'd40 || Running !== 1'b0 || Done !== 1'b0) begin
            n_err++;
            $display("FAIL arm_first: PC=%0d Running=%b Done=%b, want 40/0/0", PC, Running, Done);
        end
        cyc(0, 1, 2'd1, 0, 0, 0, 6'd0, 0, 12'd0);
        n_vec++;
        if (PC !== 12'd40 || Running !== 1'b0) begin
            n_err++;
            $display("FAIL arm_second: PC=%0d Running=%b, want 40/0", PC, Running);
        end
        cyc(0, 0, 2'd1, 0, 0, 0, 6'd0, 0, 12'd0);
        n_vec++;
        if (PC !== 12'd40 || Running !== 1'b1) begin
            n_err++;
            $display("FAIL run_entry: PC=%0d Running=%b, want 40/1", PC, Running);
        end
        cyc(0, 0, 2'd1, 0, 0, 0, 6'd0, 0, 12'($urandom));
        n_vec++;
        if (PC !== 12'd41 || Done !== 1'b0) begin
            n_err++;
            $display("FAIL run_increment: PC=%0d Done=%b, want 41/0", PC, Done);
        end
    endtask

    task automatic test_branch();
        goto_pc(100);
        n_vec++;
        if (PC !== 12'd100) begin
            n_err++;
            $display("FAIL branch_setup: PC=%0d, want 100", PC);
        end
        cyc(0, 0, 2'd0, 0, 1, 1, 6'd17, 0, 12'(-142));
        n_vec++;
        if (LutAddr !== 6'd17) begin
            n_err++;
            $display("FAIL branch_lutaddr: LutAddr=%0d, want 17", LutAddr);
        end
        n_vec++;
        if (PC !== 12'd4054) begin
            n_err++;
            $display("FAIL branch_taken_neg: PC=%0d, want 4054", PC);
        end
        goto_pc(100);
        cyc(0, 0, 2'd0, 0, 1, 0, 6'd17, 0, 12'($urandom));
        n_vec++;
        if (PC !== 12'd101) begin
            n_err++;
            $display("FAIL branch_not_taken: PC=%0d, want 101", PC);
        end
        cyc(0, 0, 2'd0, 0, 1, 1, 6'd3, 0, 12'd0);
        n_vec++;
        if (PC !== 12'd101 || Running !== 1'b1) begin
            n_err++;
            $display("FAIL self_loop: PC=%0d Running=%b, want 101/1", PC, Running);
        end
    endtask

    task automatic test_wrap();
        goto_pc(4095);
        cyc(0, 0, 2'd0, 0, 0, 1, 6'd0, 0, 12'($urandom));
        n_vec++;
        if (PC !== 12'd0) begin
            n_err++;
            $display("FAIL wrap_increment: PC=%0d, want 0", PC);
        end
        goto_pc(2);
        cyc(0, 0, 2'd0, 0, 1, 1, 6'd9, 0, 12'(-17));
        n_vec++;
        if (PC !== 12'd4081) begin
            n_err++;
            $display("FAIL wrap_branch: PC=%0d, want 4081", PC);
        end
    endtask

    task automatic test_halt_stall();
        goto_pc(60);
        cyc(0, 0, 2'd0, 1, 1, 1, 6'd1, 1, 12'd7);
        n_vec++;
        if (PC !== 12'd60 || Done !== 1'b1 || Running !== 1'b0) begin
            n_err++;
            $display("FAIL halt_stall: PC=%0d Done=%b Running=%b, want 60/1/0", PC, Done, Running);
        end
        cyc(0, 0, 2'd0, 0, 1, 1, 6'd1, 0, 12'd5);
        n_vec++;
        if (PC !== 12'd60 || Done !== 1'b1) begin
            n_err++;
            $display("FAIL done_hold: PC=%0d Done=%b, want 60/1", PC, Done);
        end
    endtask

    task automatic test_restart();
        cyc(0, 1, 2'd2, 0, 0, 0, 6'd0, 0, 12'd0);
        n_vec++;
        if (PC !== 12'd200 || Done !== 1'b0 || Running !== 1'b0) begin
            n_err++;
            $display("FAIL restart_arm: PC=%0d Done=%b Running=%b, want 200/0/0", PC, Done, Running);
        end
        cyc(0, 0, 2'd2, 0, 0, 0, 6'd0, 0, 12'd0);
        n_vec++;
        if (PC !== 12'd200 || Running !== 1'b1) begin
            n_err++;
            $display("FAIL restart_run: PC=%0d Running=%b, want 200/1", PC, Running);
        end
        cyc(0, 1, 2'd1, 0, 0, 0, 6'd0, 0, 12'd0);
        n_vec++;
        if (PC !== 12'd201 || Running !== 1'b1) begin
            n_err++;
            $display("FAIL start_in_run: PC=%0d Running=%b, want 201/1", PC, Running);
        end
    endtask

    task automatic test_reset_midrun();
        goto_pc(77);
        cyc(1, 0, 2'd0, 0, 1, 1, 6'd5, 0, 12'd9);
        n_vec++;
        if (PC !== 12'd0 || Running !== 1'b0 || Done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midrun: PC=%0d Running=%b Done=%b, want 0/0/0", PC, Running, Done);
        end
        cyc(0, 0, 2'd0, 0, 0, 0, 6'd0, 0, 12'd0);
        n_vec++;
        if (PC !== 12'd0 || Running !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold: PC=%0d Running=%b, want 0/0", PC, Running);
        end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        logic [9:0] taken_pat;
        logic [9:0] stall_pat;
        taken_pat = 10'b0001001001;
        stall_pat = 10'b0000000100;
        cyc(0, 1, 2'd0, 0, 0, 0, 6'd0, 0, 12'd0);
        cyc(0, 0, 2'd0, 0, 0, 0, 6'd0, 0, 12'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 2'd0, stall_pat[i], 1, taken_pat[i], 6'd0, (i == 9), 12'd3);
        end
        n_vec++;
        if (BranchCnt !== 16'd3 || CycleCnt !== 16'd10 || Done !== 1'b1) begin
            n_err++;
            $display("FAIL stats_count: BranchCnt=%0d CycleCnt=%0d Done=%b, want 3/10/1", BranchCnt, CycleCnt, Done);
        end
        cyc(0, 0, 2'd0, 0, 1, 1, 6'd0, 0, 12'd3);
        n_vec++;
        if (BranchCnt !== 16'd3 || CycleCnt !== 16'd10) begin
            n_err++;
            $display("FAIL stats_hold: BranchCnt=%0d CycleCnt=%0d, want 3/10", BranchCnt, CycleCnt);
        end
        cyc(0, 1, 2'd0, 0, 0, 0, 6'd0, 0, 12'd0);
        n_vec++;
        if (BranchCnt !== 16'd0 || CycleCnt !== 16'd0) begin
            n_err++;
            $display("FAIL stats_clear_arm: BranchCnt=%0d CycleCnt=%0d, want 0/0", BranchCnt, CycleCnt);
        end
    endtask
`endif

    task automatic test_random();
        logic r_rst, r_st, r_stl, r_be, r_tk, r_hlt;
        logic [1:0] r_sel;
        logic [5:0] r_idx;
        logic [D-1:0] r_tgt;
        cyc(1, 0, 2'd0, 0, 0, 0, 6'd0, 0, 12'd0);
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_sel = 2'($urandom);
            r_stl = ($urandom_range(0, 4) == 0);
            r_be  = 1'($urandom);
            r_tk  = 1'($urandom);
            r_idx = 6'($urandom);
            r_hlt = ($urandom_range(0, 24) == 0);
            r_tgt = 12'($urandom);
            cyc(r_rst, r_st, r_sel, r_stl, r_be, r_tk, r_idx, r_hlt, r_tgt);
            n_vec++;
            if (PC !== 12'(m_pc) || Running !== (m_mode == M_RUN) ||
                Done !== (m_mode == M_DONE) || LutAddr !== r_idx
`ifdef BRANCH_STATS_EN
                || BranchCnt !== 16'(m_bcnt) || CycleCnt !== 16'(m_ccnt)
`endif
               ) begin
                n_err++;
                $display("FAIL random_%0d: PC=%0d Running=%b Done=%b LutAddr=%0d, want %0d/%b/%b/%0d",
                         i, PC, Running, Done, LutAddr, m_pc, (m_mode == M_RUN), (m_mode == M_DONE), r_idx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_branch();
        test_wrap();
        test_halt_stall();
        test_restart();
        test_reset_midrun();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller for the single-cycle core; sequences instruction fetch for the selected program.
- Resolves PC-relative branches by driving the 6-bit branch-target LUT index and adding the returned signed offset to PC.
- Owns the Start/Done handshake with the test harness.
- Sits between the instruction decoder, the branch-target LUT and instruction memory.

Parameters:
D, 12, PC width in bits; instruction-memory address space is 2^D words.
P0_BASE, 0, start PC of program 0.
P1_BASE, 0, start PC of program 1 (the program table entries are LUT indices 16-17).
P2_BASE, 0, start PC of program 2 (the program table entries are LUT indices 18-23).

Ports:
Clk  in  1  system clock, all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
Start  in  1  harness start request; level sampled each cycle.
ProgSel  in  2  program to run (0, 1, 2); 3 treated as 0.
Stall  in  1  hold PC this cycle (multi-cycle memory op).
BranchEn  in  1  decoder: current instruction is a branch.
Taken  in  1  ALU: branch condition true (valid with BranchEn).
BranchIdx  in  6  LUT index field from current instruction.
Halt  in  1  decoder: current instruction is the halt opcode.
LutAddr  out  6  index presented to branch-target LUT (combinational = BranchIdx).
LutTarget  in  D  signed two's-complement PC offset returned by LUT.
PC  out  D  current fetch address.
Running  out  1  high while in RUN.
Done  out  1  high in DONE state.

Behaviour:
- States: IDLE, ARM, RUN, DONE. Reset → IDLE, PC=0, Running=0, Done=0.
- IDLE: Start=1 → ARM.
- ARM: PC loaded with base for ProgSel.
  - Start still 1 → remain ARM; PC keeps reloading with the base of the current ProgSel.
  - Start=0 → RUN. The program begins on Start falling.
- RUN: Running=1. Priority per cycle is Halt > Stall > branch > increment.
  - Halt=1 → DONE, PC holds.
  - Stall=1 → PC holds.
  - BranchEn&&Taken → PC <= PC + LutTarget.
  - Otherwise PC <= PC + 1.
- Arithmetic is D-bit modulo 2^D: PC 4095 + 1 → 0; PC 5 + (-17) → 4084. No saturation, no error flag.
- LutTarget is used only when BranchEn&&Taken; X/garbage on LutTarget otherwise must not affect PC.
- Target value 0 is legal and holds PC (self-loop); the sequencer stays in RUN.
- DONE: Done=1, Running=0, PC holds. Start=1 → ARM (new run; ProgSel re-sampled).
- Start=1 while in RUN is ignored.
- Reset asserted in any state overrides everything next edge → IDLE, PC=0.
- Latency: branch decision to new PC is one edge; LutAddr follows BranchIdx with zero latency.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined:
  - Adds output BranchCnt [15:0]: count of taken branches in the current run, saturating at 16'hFFFF.
  - Adds output CycleCnt [15:0]: cycles spent in RUN, saturating at 16'hFFFF.
  - Both clear on Reset and on entry to ARM, and hold in DONE.
  - A stalled cycle increments CycleCnt only.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, ProgSel=1, P1_BASE=40, Start high 2 cycles then low → ARM for 2 cycles with PC=40; RUN the next cycle, PC=41 one cycle later; Done=0.
- In RUN at PC=100: BranchEn=1, Taken=1, BranchIdx=17, LutTarget=-142 → LutAddr=17, next PC=4054; with Taken=0 next PC=101.
- PC=4095, no branch → PC=0; PC=2, LutTarget=-17, taken → PC=4081.
- Halt and Stall asserted the same cycle at PC=60 → DONE; PC=60, Done=1, Running=0.
- Start pulse in DONE with ProgSel=2, P2_BASE=200 → ARM, then RUN from PC=200.
- Reset asserted mid-RUN at PC=77 with a branch pending → next edge IDLE, PC=0, Done=0. With BRANCH_STATS_EN: 3 taken branches plus 1 stall in 10 RUN cycles → BranchCnt=3, CycleCnt=10.
